// File: rtl/cci_mpf_shim_rd_arb.sv
// Round-robin arbiter sharing the MPF c0 read-request channel among N_CLIENTS requesters,
// with client tagging in Mdata, a global credit limit and response steering. Stats: CCI_MPF_RD_ARB_STATS_EN.
module cci_mpf_shim_rd_arb #(
  parameter int N_CLIENTS       = 4,
  parameter int CLIENT_IDX_BITS = $clog2(N_CLIENTS),
  parameter int ADDR_WIDTH      = 42,
  parameter int MDATA_WIDTH     = 16,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [N_CLIENTS-1:0]                            cl_req_valid,
  input  logic [N_CLIENTS*ADDR_WIDTH-1:0]                 cl_req_addr,
  input  logic [N_CLIENTS*(MDATA_WIDTH-CLIENT_IDX_BITS)-1:0] cl_req_mdata,
  output logic [N_CLIENTS-1:0]                            cl_req_grant,
  output logic                                            rd_req_valid,
  output logic [ADDR_WIDTH-1:0]                           rd_req_addr,
  output logic [MDATA_WIDTH-1:0]                          rd_req_mdata,
  input  logic                                            rd_almost_full,
  input  logic                                            rd_rsp_valid,
  input  logic [MDATA_WIDTH-1:0]                          rd_rsp_mdata,
  input  logic [511:0]                                    rd_rsp_data,
  output logic [N_CLIENTS-1:0]                            cl_rsp_valid,
  output logic [MDATA_WIDTH-CLIENT_IDX_BITS-1:0]          cl_rsp_mdata,
  output logic [511:0]                                    cl_rsp_data,
  output logic [N_CLIENTS-1:0]                            cl_idle,
  output logic [N_CLIENTS*32-1:0]                         stat_grants,
  output logic [31:0]                                     stat_stall_cycles
);
  localparam int CMW = MDATA_WIDTH - CLIENT_IDX_BITS;

  logic [CLIENT_IDX_BITS-1:0] rr_ptr_q, rr_ptr_d, grant_idx, cand, rsp_tag;
  logic                       grant_any, can_issue;
  logic [N_CLIENTS-1:0]       grant;
  logic [7:0]                 outstanding_q, outstanding_d;
  logic [7:0]                 cnt_q [N_CLIENTS];
  logic [7:0]                 cnt_d [N_CLIENTS];
  logic [N_CLIENTS-1:0]       cl_idle_q, cl_idle_d;
  logic                       rd_req_valid_q, rd_req_valid_d;
  logic [ADDR_WIDTH-1:0]      rd_req_addr_q, rd_req_addr_d;
  logic [MDATA_WIDTH-1:0]     rd_req_mdata_q, rd_req_mdata_d;
  logic [N_CLIENTS-1:0]       cl_rsp_valid_q, cl_rsp_valid_d;
  logic [CMW-1:0]             cl_rsp_mdata_q, cl_rsp_mdata_d;
  logic [511:0]               cl_rsp_data_q, cl_rsp_data_d;

  // Circular search from rr_ptr; the index sum wraps naturally because N_CLIENTS is a power of two.
  always_comb begin
    can_issue = !rd_almost_full && (int'(outstanding_q) < MAX_OUTSTANDING);
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    grant     = '0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      cand = rr_ptr_q + CLIENT_IDX_BITS'(k);
      if (can_issue && !reset && !grant_any && cl_req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d       = grant_any ? grant_idx + CLIENT_IDX_BITS'(1) : rr_ptr_q;
    rd_req_valid_d = grant_any;
    rd_req_addr_d  = grant_any ? cl_req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH] : rd_req_addr_q;
    rd_req_mdata_d = grant_any ? {grant_idx, cl_req_mdata[grant_idx*CMW +: CMW]} : rd_req_mdata_q;

    rsp_tag        = rd_rsp_mdata[MDATA_WIDTH-1 -: CLIENT_IDX_BITS];
    cl_rsp_valid_d = '0;
    if (rd_rsp_valid) cl_rsp_valid_d[rsp_tag] = 1'b1;
    cl_rsp_mdata_d = rd_rsp_valid ? rd_rsp_mdata[CMW-1:0] : cl_rsp_mdata_q;
    cl_rsp_data_d  = rd_rsp_valid ? rd_rsp_data : cl_rsp_data_q;

    // A response with nothing outstanding leaves the counter pinned at zero.
    outstanding_d = outstanding_q;
    if (grant_any && !rd_rsp_valid)
      outstanding_d = outstanding_q + 8'd1;
    else if (!grant_any && rd_rsp_valid && outstanding_q != 8'd0)
      outstanding_d = outstanding_q - 8'd1;

    for (int i = 0; i < N_CLIENTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (grant[i] && !(rd_rsp_valid && rsp_tag == CLIENT_IDX_BITS'(i)))
        cnt_d[i] = cnt_q[i] + 8'd1;
      else if (!grant[i] && rd_rsp_valid && rsp_tag == CLIENT_IDX_BITS'(i) && cnt_q[i] != 8'd0)
        cnt_d[i] = cnt_q[i] - 8'd1;
      cl_idle_d[i] = (cnt_d[i] == 8'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q       <= '0;
      outstanding_q  <= '0;
      cl_idle_q      <= '1;
      rd_req_valid_q <= 1'b0;
      rd_req_addr_q  <= '0;
      rd_req_mdata_q <= '0;
      cl_rsp_valid_q <= '0;
      cl_rsp_mdata_q <= '0;
      cl_rsp_data_q  <= '0;
      for (int i = 0; i < N_CLIENTS; i++) cnt_q[i] <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      outstanding_q  <= outstanding_d;
      cl_idle_q      <= cl_idle_d;
      rd_req_valid_q <= rd_req_valid_d;
      rd_req_addr_q  <= rd_req_addr_d;
      rd_req_mdata_q <= rd_req_mdata_d;
      cl_rsp_valid_q <= cl_rsp_valid_d;
      cl_rsp_mdata_q <= cl_rsp_mdata_d;
      cl_rsp_data_q  <= cl_rsp_data_d;
      for (int i = 0; i < N_CLIENTS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(rd_rsp_valid && outstanding_q == 8'd0))
        else $error("read response received with no reads outstanding");
    end
  end
`endif

  assign cl_req_grant = grant;
  assign rd_req_valid = rd_req_valid_q;
  assign rd_req_addr  = rd_req_addr_q;
  assign rd_req_mdata = rd_req_mdata_q;
  assign cl_rsp_valid = cl_rsp_valid_q;
  assign cl_rsp_mdata = cl_rsp_mdata_q;
  assign cl_rsp_data  = cl_rsp_data_q;
  assign cl_idle      = cl_idle_q;

`ifdef CCI_MPF_RD_ARB_STATS_EN
  logic [31:0] stat_grants_q [N_CLIENTS];
  logic [31:0] stat_grants_d [N_CLIENTS];
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    for (int i = 0; i < N_CLIENTS; i++)
      stat_grants_d[i] = grant[i] ? stat_grants_q[i] + 32'd1 : stat_grants_q[i];
    stat_stall_d = ((|cl_req_valid) && !can_issue) ? stat_stall_q + 32'd1 : stat_stall_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CLIENTS; i++) stat_grants_q[i] <= '0;
      stat_stall_q <= '0;
    end else begin
      for (int i = 0; i < N_CLIENTS; i++) stat_grants_q[i] <= stat_grants_d[i];
      stat_stall_q <= stat_stall_d;
    end
  end

  for (genvar g = 0; g < N_CLIENTS; g++) begin : g_stat
    assign stat_grants[g*32 +: 32] = stat_grants_q[g];
  end
  assign stat_stall_cycles = stat_stall_q;
`else
  assign stat_grants       = '0;
  assign stat_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_cci_mpf_shim_rd_arb.sv
// Bench for cci_mpf_shim_rd_arb: directed scenarios plus random traffic checked against
// a queue-based model of arbitration order, credits and response routing.
module tb_cci_mpf_shim_rd_arb;
  localparam int N    = 4;
  localparam int AW   = 42;
  localparam int MW   = 16;
  localparam int CMW  = 14;
  localparam int MAXO = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     cl_req_valid;
  logic [N*AW-1:0]  cl_req_addr;
  logic [N*CMW-1:0] cl_req_mdata;
  logic [N-1:0]     cl_req_grant;
  logic             rd_req_valid;
  logic [AW-1:0]    rd_req_addr;
  logic [MW-1:0]    rd_req_mdata;
  logic             rd_almost_full;
  logic             rd_rsp_valid;
  logic [MW-1:0]    rd_rsp_mdata;
  logic [511:0]     rd_rsp_data;
  logic [N-1:0]     cl_rsp_valid;
  logic [CMW-1:0]   cl_rsp_mdata;
  logic [511:0]     cl_rsp_data;
  logic [N-1:0]     cl_idle;
  logic [N*32-1:0]  stat_grants;
  logic [31:0]      stat_stall_cycles;

  cci_mpf_shim_rd_arb #(
    .N_CLIENTS(N), .ADDR_WIDTH(AW), .MDATA_WIDTH(MW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset(reset),
    .cl_req_valid(cl_req_valid), .cl_req_addr(cl_req_addr), .cl_req_mdata(cl_req_mdata),
    .cl_req_grant(cl_req_grant),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata),
    .rd_almost_full(rd_almost_full),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_mdata(rd_rsp_mdata), .rd_rsp_data(rd_rsp_data),
    .cl_rsp_valid(cl_rsp_valid), .cl_rsp_mdata(cl_rsp_mdata), .cl_rsp_data(cl_rsp_data),
    .cl_idle(cl_idle), .stat_grants(stat_grants), .stat_stall_cycles(stat_stall_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int            m_rr;
  int            m_out;
  int            m_cnt [N];
  int            q [$];
  logic [AW-1:0] cl_addr [N];
  logic [CMW-1:0] cl_md [N];
  logic [N-1:0]  pend;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic new_req(input int i);
    cl_addr[i] = AW'({$urandom, $urandom});
    cl_md[i]   = CMW'($urandom);
  endtask

  task automatic step(input logic [N-1:0] vmask, input logic af, input bit rsp,
                      input int rsp_tag_req, input logic [CMW-1:0] rsp_low, input bit rst);
    int gi, tag;
    logic [N-1:0] exp_grant;
    logic exp_req_v;
    logic [AW-1:0] exp_addr;
    logic [MW-1:0] exp_md;
    logic [511:0] data;
    logic [N-1:0] exp_idle;

    @(negedge clk);
    reset          = rst;
    cl_req_valid   = vmask;
    rd_almost_full = af;
    for (int i = 0; i < N; i++) begin
      cl_req_addr[i*AW +: AW]   = cl_addr[i];
      cl_req_mdata[i*CMW +: CMW] = cl_md[i];
    end
    tag = -1;
    if (rsp && !rst && q.size() > 0) begin
      tag = (rsp_tag_req < 0) ? q[0] : rsp_tag_req;
      if (m_cnt[tag] == 0) tag = -1;
    end
    data = '0;
    if (tag >= 0) begin
      for (int j = 0; j < 16; j++) data[j*32 +: 32] = $urandom;
      rd_rsp_valid = 1'b1;
      rd_rsp_mdata = {2'(tag), rsp_low};
      rd_rsp_data  = data;
    end else begin
      rd_rsp_valid = 1'b0;
    end
    #1;

    gi = -1;
    if (!rst && !af && m_out < MAXO)
      for (int k = 0; k < N; k++)
        if (gi < 0 && vmask[(m_rr + k) % N]) gi = (m_rr + k) % N;
    exp_grant = (gi >= 0) ? N'(1 << gi) : '0;
    chk("grant", 512'(cl_req_grant), 512'(exp_grant));

    exp_req_v = 1'b0;
    exp_addr  = '0;
    exp_md    = '0;
    if (rst) begin
      m_rr = 0; m_out = 0; q.delete();
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      if (gi >= 0) begin
        exp_req_v = 1'b1;
        exp_addr  = cl_addr[gi];
        exp_md    = {2'(gi), cl_md[gi]};
        m_rr = (gi + 1) % N;
        m_out++;
        m_cnt[gi]++;
        q.push_back(gi);
        pend[gi] = 1'b0;
        new_req(gi);
      end
      if (tag >= 0) begin
        m_out--;
        m_cnt[tag]--;
        for (int j = 0; j < q.size(); j++)
          if (q[j] == tag) begin q.delete(j); break; end
      end
    end
    for (int i = 0; i < N; i++) exp_idle[i] = (m_cnt[i] == 0);

    @(posedge clk);
    #1;
    chk("rd_req_valid", 512'(rd_req_valid), 512'(exp_req_v));
    if (exp_req_v || rst) begin
      chk("rd_req_addr", 512'(rd_req_addr), 512'(exp_addr));
      chk("rd_req_mdata", 512'(rd_req_mdata), 512'(exp_md));
    end
    chk("cl_rsp_valid", 512'(cl_rsp_valid), (tag >= 0) ? 512'(1 << tag) : 512'(0));
    if (tag >= 0) begin
      chk("cl_rsp_mdata", 512'(cl_rsp_mdata), 512'(rsp_low));
      chk("cl_rsp_data", cl_rsp_data, data);
    end
    if (rst) begin
      chk("rst_rsp_mdata", 512'(cl_rsp_mdata), 512'(0));
      chk("rst_rsp_data", cl_rsp_data, 512'(0));
    end
    chk("cl_idle", 512'(cl_idle), 512'(exp_idle));
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() > 0 && guard < 50) begin
      step('0, 1'b0, 1'b1, -1, CMW'($urandom), 1'b0);
      guard++;
    end
    chk("drain_done", 512'(q.size()), 512'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; cl_req_valid = '0; cl_req_addr = '0; cl_req_mdata = '0;
    rd_almost_full = 1'b0; rd_rsp_valid = 1'b0; rd_rsp_mdata = '0; rd_rsp_data = '0;
    pend = '0; m_rr = 0; m_out = 0;
    for (int i = 0; i < N; i++) begin m_cnt[i] = 0; new_req(i); end

    // Reset
    step('0, 1'b0, 1'b0, -1, '0, 1'b1);
    step('0, 1'b0, 1'b0, -1, '0, 1'b1);

    // Fairness: all valid, responses keep credits free -> 0,1,2,3,0,1,2,3
    for (int c = 0; c < 8; c++) step(4'hF, 1'b0, 1'b1, -1, CMW'($urandom), 1'b0);

    // Almost-full window with clients valid
    for (int c = 0; c < 12; c++)
      step(4'hF, (c >= 3 && c <= 7), 1'b1, -1, CMW'($urandom), 1'b0);
    drain();

    // Reset in the middle of traffic; first grant afterwards goes to client 0
    step(4'hF, 1'b0, 1'b0, -1, '0, 1'b0);
    step(4'hF, 1'b0, 1'b0, -1, '0, 1'b0);
    step(4'hF, 1'b0, 1'b0, -1, '0, 1'b1);
    step(4'hF, 1'b0, 1'b0, -1, '0, 1'b0);
    chk("post_reset_first_grant", 512'(q[0]), 512'(0));
    drain();
    step('0, 1'b0, 1'b0, -1, '0, 1'b1);

    // Credit limit: 4 grants then stall; a client-2 response frees one credit
    for (int c = 0; c < 6; c++) step(4'hF, 1'b0, 1'b0, -1, '0, 1'b0);
    chk("credit_full", 512'(q.size()), 512'(MAXO));
    step(4'hF, 1'b0, 1'b1, 2, CMW'($urandom), 1'b0);
    step(4'hF, 1'b0, 1'b0, -1, '0, 1'b0);
    step(4'hF, 1'b0, 1'b0, -1, '0, 1'b0);
    chk("credit_after_rsp", 512'(q.size()), 512'(MAXO));

    // Response routing: 16'hC00A -> client 3, mdata 14'h000A
    step('0, 1'b0, 1'b1, 3, 14'h000A, 1'b0);
    drain();

    // Idle tracking on client 1
    step(4'b0010, 1'b0, 1'b0, -1, '0, 1'b0);
    step('0, 1'b0, 1'b0, -1, '0, 1'b0);
    step('0, 1'b0, 1'b1, 1, CMW'($urandom), 1'b0);
    step('0, 1'b0, 1'b0, -1, '0, 1'b0);

    // Random traffic with one reset midway
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) pend[i] = 1'b1;
      if (c == 200) begin
        pend = '0;
        step('0, 1'b0, 1'b0, -1, '0, 1'b1);
      end else begin
        step(pend, ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 1),
             -1, CMW'($urandom), 1'b0);
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
